// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between I-cache line fills and
// D-cache fills/write-backs. Optional round-robin tie-break: MEM_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 64,
  localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_rvalid_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [63:0]       dc_wdata_i,
  output logic              dc_rvalid_o,
  output logic              dc_wnext_o,
  output logic              dc_done_o,
  output logic [63:0]       rdata_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 8 - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

  state_t              state_q, state_d;
  logic                owner_q;        // 0 = I-cache, 1 = D-cache
  logic                we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [BEAT_W-1:0]   beat_q;

  logic                grant;
  logic                grant_dc;
  logic [ADDR_W-1:0]   grant_base;
  logic [ADDR_W-1:0]   beat_off;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  // On a tie the requester that was not served last wins.
  assign grant_dc = dc_req_i && (!ic_req_i || !last_owner_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_owner_q <= 1'b0;
    end else if (grant) begin
      last_owner_q <= grant_dc;
    end
  end
`else
  // The D-cache miss belongs to the older instruction, so it wins ties.
  assign grant_dc = dc_req_i;
`endif

  assign grant_base = (grant_dc ? dc_addr_i : ic_addr_i) & ~LINE_MASK;
  // Base is line-aligned, so OR-ing the word offset never carries.
  assign beat_off   = ADDR_W'({beat_q, 3'b000});

  assign rdata_o = mem_rdata_i;
  assign beat_o  = beat_q;
  assign busy_o  = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    grant       = 1'b0;
    ic_rvalid_o = 1'b0;
    ic_done_o   = 1'b0;
    dc_rvalid_o = 1'b0;
    dc_wnext_o  = 1'b0;
    dc_done_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          grant   = 1'b1;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_addr_o = base_q | beat_off;
        if (owner_q && we_q) begin
          mem_wdata_o = dc_wdata_i;
        end
        if (mem_ready_i) begin
          dc_wnext_o  = owner_q && we_q;
          dc_rvalid_o = owner_q && !we_q;
          ic_rvalid_o = !owner_q;
          if (beat_q == BEAT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        ic_done_o = !owner_q;
        dc_done_o = owner_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_dc;
        we_q    <= grant_dc && dc_we_i;
        base_q  <= grant_base;
        beat_q  <= '0;
      end else if (state_q == ST_BURST && mem_ready_i) begin
        beat_q <= beat_q + 1'b1;   // wraps to 0 after the last beat
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transfers,
// scoreboarded beats/done pulses, tie, reset and stall sequences.
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int AW = 64;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          ic_req_i, dc_req_i, dc_we_i;
  logic [AW-1:0] ic_addr_i, dc_addr_i;
  logic [63:0]   dc_wdata_i, mem_rdata_i, rdata_o, mem_wdata_o;
  logic          ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_wnext_o, dc_done_o;
  logic [1:0]    beat_o;
  logic          busy_o, mem_req_o, mem_we_o, mem_ready_i;
  logic [AW-1:0] mem_addr_o;

  mem_port_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_rvalid_o(dc_rvalid_o),
    .dc_wnext_o(dc_wnext_o), .dc_done_o(dc_done_o),
    .rdata_o(rdata_o), .beat_o(beat_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] rdata_of(input logic [63:0] a);
    return a ^ 64'h5A5A_5A5A_0F0F_0F0F;
  endfunction

  function automatic logic [63:0] wdata_of(input logic [1:0] b);
    return 64'hC0DE_1111_0000_0000 + 64'(b) * 64'h0101;
  endfunction

  // Memory model returns address-derived data; the D-cache supplies a
  // beat-indexed write word.
  assign mem_rdata_i = rdata_of(mem_addr_o);
  assign dc_wdata_i  = wdata_of(beat_o);

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic        dc;
    logic [1:0]  beat;
  } sb_t;

  typedef struct {
    logic        dc;
    logic        we;
    logic [63:0] addr;
    int          mode;      // 0 ready always, 1 toggle 1/0, 2 stall 10 at beat 1
    logic [63:0] exp_base;
    int          exp_busy;
  } vec_t;

  sb_t  sb_beats[$];
  logic sb_done[$];
  logic sb_en = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  mon_e;
  logic mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic push_txn(input logic dc, input logic we, input logic [63:0] base);
    for (int i = 0; i < LW; i++) begin
      sb_beats.push_back('{addr: base + 64'(i) * 8, we: we, dc: dc, beat: 2'(i)});
    end
    sb_done.push_back(dc);
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && sb_en) begin
      if (mem_req_o && mem_ready_i) begin
        if (sb_beats.size() == 0) begin
          fail_now("sb_beat_underflow");
        end else begin
          mon_e = sb_beats.pop_front();
          check("beat_addr",   mem_addr_o,  mon_e.addr);
          check("beat_we",     mem_we_o,    mon_e.we);
          check("beat_idx",    beat_o,      mon_e.beat);
          check("ic_rvalid",   ic_rvalid_o, !mon_e.dc && !mon_e.we);
          check("dc_rvalid",   dc_rvalid_o, mon_e.dc && !mon_e.we);
          check("dc_wnext",    dc_wnext_o,  mon_e.we);
          check("beat_wdata",  mem_wdata_o, mon_e.we ? wdata_of(mon_e.beat) : 64'd0);
          check("beat_rdata",  rdata_o,     rdata_of(mon_e.addr));
        end
      end else if (mem_req_o) begin
        check("wait_strobes", {ic_rvalid_o, dc_rvalid_o, dc_wnext_o}, 0);
      end
      if (ic_done_o || dc_done_o) begin
        if (sb_done.size() == 0) begin
          fail_now("sb_done_underflow");
        end else begin
          mon_d = sb_done.pop_front();
          check("done_dc",     dc_done_o, mon_d);
          check("done_ic",     ic_done_o, !mon_d);
          check("done_memreq", mem_req_o, 0);
          check("done_busy",   busy_o,    1);
        end
      end
    end
  end

  // Runs the memory side until one done pulse; returns at posedge+1 of the
  // IDLE cycle that follows it.
  task automatic wait_done(input int mode, input logic [63:0] base,
                           output logic was_dc, output int busy_cycles, output int cycles);
    int   k = 0;
    int   kk;
    logic seen = 1'b0;
    was_dc = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      kk = -1;
      if (mem_req_o) begin
        kk = k;
        mem_ready_i = (mode == 0) || (mode == 1 && k % 2 == 0) ||
                      (mode == 2 && (k == 0 || k > 10));
        k++;
      end else begin
        mem_ready_i = 1'b0;
      end
      @(negedge clk_i);
      cycles++;
      if (busy_o) busy_cycles++;
      if (mode == 2 && kk >= 1 && kk <= 10) begin
        check("stall_addr", mem_addr_o, base + 64'd8);
        check("stall_busy", busy_o, 1);
      end
      if (ic_done_o || dc_done_o) begin
        seen = 1'b1;
        was_dc = dc_done_o;
      end
      @(posedge clk_i);
      #1;
    end
    mem_ready_i = 1'b0;
    if (!seen) fail_now("done_timeout");
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    logic was_dc, first_dc, found;
    int   busy_n, cyc_n;

    vecs[0] = '{1'b0, 1'b0, 64'h1234, 0, 64'h1220, 5};
    vecs[1] = '{1'b1, 1'b1, 64'h40, 1, 64'h40, 8};
    vecs[2] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 0, 64'hFFFF_FFFF_FFFF_FFE0, 5};
    vecs[3] = '{1'b0, 1'b0, 64'h1F, 1, 64'h0, 8};
    vecs[4] = '{1'b1, 1'b1, 64'hABCD, 0, 64'hABC0, 5};
    vecs[5] = '{1'b1, 1'b0, 64'h2008, 2, 64'h2000, 15};
    vecs[6] = '{1'b0, 1'b0, 64'h3FF4, 2, 64'h3FE0, 15};

    rst_n_i = 1'b0;
    ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0; mem_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy",    busy_o,     0);
    check("rst_memreq",  mem_req_o,  0);
    check("rst_beat",    beat_o,     0);
    check("rst_addr",    mem_addr_o, 0);
    check("rst_done",    {ic_done_o, dc_done_o}, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single-requester transfers from the table.
    for (int i = 0; i < 7; i++) begin
      push_txn(vecs[i].dc, vecs[i].we, vecs[i].exp_base);
      if (vecs[i].dc) begin
        dc_req_i = 1'b1; dc_we_i = vecs[i].we; dc_addr_i = vecs[i].addr;
      end else begin
        ic_req_i = 1'b1; ic_addr_i = vecs[i].addr;
      end
      wait_done(vecs[i].mode, vecs[i].exp_base, was_dc, busy_n, cyc_n);
      ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0;
      check("vec_owner",     was_dc, vecs[i].dc);
      check("vec_busy_len",  busy_n, vecs[i].exp_busy);
      check("vec_idle_busy", busy_o, 0);
    end

    // Asynchronous reset in the middle of a fill.
    sb_en = 1'b0;
    ic_addr_i = 64'h5678; ic_req_i = 1'b1; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req_o && beat_o == 2'd2) begin
        found = 1'b1;
      end else begin
        mem_ready_i = mem_req_o;
        @(posedge clk_i);
        #1;
      end
    end
    if (!found) fail_now("rst_reach_beat2");
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_busy",   busy_o,      0);
    check("arst_memreq", mem_req_o,   0);
    check("arst_rvalid", ic_rvalid_o, 0);
    check("arst_beat",   beat_o,      0);
    check("arst_addr",   mem_addr_o,  0);
    check("arst_we",     mem_we_o,    0);
    check("arst_wdata",  mem_wdata_o, 0);
    mem_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("arst_no_done", {ic_done_o, dc_done_o}, 0);
    end
    @(posedge clk_i);
    #1;
    sb_en = 1'b1;
    push_txn(1'b0, 1'b0, 64'h5660);
    rst_n_i = 1'b1;
    wait_done(0, 64'h5660, was_dc, busy_n, cyc_n);
    ic_req_i = 1'b0;
    check("rst_restart_owner", was_dc, 0);
    check("rst_restart_busy",  busy_n, 5);

    // Tie A: D-cache first, I-cache granted in the following IDLE cycle.
    push_txn(1'b1, 1'b0, 64'h300);
    push_txn(1'b0, 1'b0, 64'h4400);
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 64'h318;
    ic_req_i = 1'b1; ic_addr_i = 64'h4408;
    wait_done(0, 64'h300, was_dc, busy_n, cyc_n);
    dc_req_i = 1'b0;
    check("tieA_first_dc", was_dc, 1);
    check("tieA_gap_idle", busy_o, 0);
    wait_done(0, 64'h4400, was_dc, busy_n, cyc_n);
    ic_req_i = 1'b0;
    check("tieA_second_ic", was_dc, 0);
    check("tieA_ic_latency", cyc_n, 6);

    // Tie B: D-cache wins again, then keeps requesting, forming a second tie.
    push_txn(1'b1, 1'b1, 64'h820);
    dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 64'h820;
    ic_req_i = 1'b1; ic_addr_i = 64'h900;
    wait_done(1, 64'h820, was_dc, busy_n, cyc_n);
    check("tieB_first_dc", was_dc, 1);
    dc_we_i = 1'b0; dc_addr_i = 64'hA10;
`ifdef MEM_ARB_RR_EN
    first_dc = 1'b0;
    push_txn(1'b0, 1'b0, 64'h900);
    push_txn(1'b1, 1'b0, 64'hA00);
`else
    first_dc = 1'b1;
    push_txn(1'b1, 1'b0, 64'hA00);
    push_txn(1'b0, 1'b0, 64'h900);
`endif
    wait_done(0, 64'h0, was_dc, busy_n, cyc_n);
    check("tieB_second_winner", was_dc, first_dc);
    if (was_dc) dc_req_i = 1'b0;
    else        ic_req_i = 1'b0;
    wait_done(0, 64'h0, was_dc, busy_n, cyc_n);
    check("tieB_third_winner", was_dc, !first_dc);
    ic_req_i = 1'b0; dc_req_i = 1'b0;

    repeat (2) @(posedge clk_i);
    check("sb_beats_empty", sb_beats.size(), 0);
    check("sb_done_empty",  sb_done.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
